// File: rtl/shared_match_pe_arbiter_pkg.sv
// Shared parameters for the match-PE arbiter: requester/ID-FIFO defaults and width helpers.
// Width macros fall back to local defaults when the including build does not provide them.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif
`ifndef LAZY_LEN_LOG2
`define LAZY_LEN_LOG2 4
`endif
`ifndef MATCH_LEN_WIDTH
`define MATCH_LEN_WIDTH 8
`endif

package shared_match_pe_arbiter_pkg;

  localparam int NUM_REQ_DEFAULT  = 4;
  localparam int DEPTH_DEFAULT    = 8;
  localparam int REQ_ID_W_DEFAULT = $clog2(NUM_REQ_DEFAULT);

  // Requester-ID width, kept at least 1 bit so a single-requester build still elaborates.
  function automatic int id_width(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

  // Occupancy counter width: must represent DEPTH itself, not just DEPTH-1.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/shared_match_pe_arbiter_id_fifo.sv
// arb_id_fifo: in-order FIFO of requester IDs awaiting a match-PE response.
// Control (pointers, count) is reset; the storage array is not.
module arb_id_fifo
  import shared_match_pe_arbiter_pkg::*;
#(
  parameter int ID_W  = REQ_ID_W_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        push,
  input  logic [ID_W-1:0]             push_id,
  input  logic                        pop,
  output logic [ID_W-1:0]             head_id,
  output logic [cnt_width(DEPTH)-1:0] count,
  output logic                        nonempty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = cnt_width(DEPTH);

  logic [ID_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      // DEPTH is a power of two, so the pointers wrap by natural overflow.
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_id;
  end

  assign head_id  = mem[rd_ptr];
  assign count    = cnt;
  assign nonempty = (cnt != '0);

endmodule

// File: rtl/shared_match_pe_arbiter.sv
// Round-robin arbiter sharing one match PE among NUM_REQ job PEs, with in-order response routing.
// Optional performance counters are enabled by defining SHARED_ARB_PERF_CNT_EN.
module shared_match_pe_arbiter
  import shared_match_pe_arbiter_pkg::*;
#(
  parameter int NUM_REQ  = NUM_REQ_DEFAULT,
  parameter int ADDR_W   = `ADDR_WIDTH,
  parameter int TAG_BITS = `LAZY_LEN_LOG2,
  parameter int MLEN_W   = `MATCH_LEN_WIDTH,
  parameter int DEPTH    = DEPTH_DEFAULT
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0]    req_head_addr,
  input  logic [NUM_REQ*ADDR_W-1:0]    req_history_addr,
  input  logic [NUM_REQ*TAG_BITS-1:0]  req_tag,
  output logic                         pe_req_valid,
  input  logic                         pe_req_ready,
  output logic [ADDR_W-1:0]            pe_req_head_addr,
  output logic [ADDR_W-1:0]            pe_req_history_addr,
  output logic [TAG_BITS-1:0]          pe_req_tag,
  input  logic                         pe_resp_valid,
  output logic                         pe_resp_ready,
  input  logic [TAG_BITS-1:0]          pe_resp_tag,
  input  logic [MLEN_W-1:0]            pe_resp_match_len,
  output logic [NUM_REQ-1:0]           resp_valid,
  input  logic [NUM_REQ-1:0]           resp_ready,
  output logic [NUM_REQ*TAG_BITS-1:0]  resp_tag,
  output logic [NUM_REQ*MLEN_W-1:0]    resp_match_len,
  output logic                         err_orphan_resp
`ifdef SHARED_ARB_PERF_CNT_EN
  ,
  output logic [NUM_REQ*32-1:0]        perf_grant_cnt,
  output logic [31:0]                  perf_stall_cnt
`endif
);

  localparam int ID_W  = id_width(NUM_REQ);
  localparam int CNT_W = cnt_width(DEPTH);

  logic [ID_W-1:0]     rr_ptr;
  logic [ID_W-1:0]     grant_idx_p0;
  logic                grant_any_p0;
  logic                grant_p0;
  logic                stage_free_p0;
  logic                vld_p1;
  logic [ADDR_W-1:0]   head_addr_p1;
  logic [ADDR_W-1:0]   hist_addr_p1;
  logic [TAG_BITS-1:0] tag_p1;
  logic [ID_W-1:0]     fifo_head;
  logic [CNT_W-1:0]    fifo_count;
  logic                fifo_nonempty;
  logic                resp_pop;

  // p0: round-robin arbitration; scanning offsets high-to-low lets the nearest requester win.
  always_comb begin
    logic [ID_W-1:0] idx;
    idx          = '0;
    grant_any_p0 = 1'b0;
    grant_idx_p0 = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (req_valid[idx]) begin
        grant_any_p0 = 1'b1;
        grant_idx_p0 = idx;
      end
    end
  end

  assign stage_free_p0 = !vld_p1 || pe_req_ready;
  assign grant_p0      = grant_any_p0 && stage_free_p0 && (fifo_count < CNT_W'(DEPTH));

  always_comb begin
    req_ready = '0;
    if (grant_p0) req_ready[grant_idx_p0] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (grant_p0) begin
      rr_ptr <= (grant_idx_p0 == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx_p0 + 1'b1;
    end
  end

  // p1: output stage toward the match PE; data holds while the PE back-pressures.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
    end else if (grant_p0) begin
      vld_p1 <= 1'b1;
    end else if (pe_req_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (grant_p0) begin
      head_addr_p1 <= req_head_addr[int'(grant_idx_p0)*ADDR_W +: ADDR_W];
      hist_addr_p1 <= req_history_addr[int'(grant_idx_p0)*ADDR_W +: ADDR_W];
      tag_p1       <= req_tag[int'(grant_idx_p0)*TAG_BITS +: TAG_BITS];
    end
  end

  assign pe_req_valid        = vld_p1;
  assign pe_req_head_addr    = head_addr_p1;
  assign pe_req_history_addr = hist_addr_p1;
  assign pe_req_tag          = tag_p1;

  arb_id_fifo #(
    .ID_W  (ID_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (grant_p0),
    .push_id  (grant_idx_p0),
    .pop      (resp_pop),
    .head_id  (fifo_head),
    .count    (fifo_count),
    .nonempty (fifo_nonempty)
  );

  // Response path: the PE answers in order, so the FIFO head names the destination lane.
  always_comb begin
    resp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      resp_valid[i] = pe_resp_valid && fifo_nonempty && (fifo_head == ID_W'(i));
    end
  end

  assign pe_resp_ready  = fifo_nonempty && resp_ready[fifo_head];
  assign resp_pop       = pe_resp_valid && pe_resp_ready;
  assign resp_tag       = {NUM_REQ{pe_resp_tag}};
  assign resp_match_len = {NUM_REQ{pe_resp_match_len}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_orphan_resp <= 1'b0;
    end else if (pe_resp_valid && !fifo_nonempty) begin
      err_orphan_resp <= 1'b1;
    end
  end

`ifdef SHARED_ARB_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_grant_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant_p0 && (grant_idx_p0 == ID_W'(i)))
          perf_grant_cnt[i*32 +: 32] <= perf_grant_cnt[i*32 +: 32] + 32'd1;
      end
      if ((|req_valid) && !grant_p0) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_shared_match_pe_arbiter.sv
// Directed self-checking bench for shared_match_pe_arbiter (NUM_REQ=4, DEPTH=8).
module tb_shared_match_pe_arbiter;

  localparam int NR = 4;
  localparam int AW = 16;
  localparam int TW = 4;
  localparam int MW = 8;
  localparam int DP = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_ready;
  logic [NR*AW-1:0] req_head_addr;
  logic [NR*AW-1:0] req_history_addr;
  logic [NR*TW-1:0] req_tag;
  logic             pe_req_valid;
  logic             pe_req_ready;
  logic [AW-1:0]    pe_req_head_addr;
  logic [AW-1:0]    pe_req_history_addr;
  logic [TW-1:0]    pe_req_tag;
  logic             pe_resp_valid;
  logic             pe_resp_ready;
  logic [TW-1:0]    pe_resp_tag;
  logic [MW-1:0]    pe_resp_match_len;
  logic [NR-1:0]    resp_valid;
  logic [NR-1:0]    resp_ready;
  logic [NR*TW-1:0] resp_tag;
  logic [NR*MW-1:0] resp_match_len;
  logic             err_orphan_resp;
`ifdef SHARED_ARB_PERF_CNT_EN
  logic [NR*32-1:0] perf_grant_cnt;
  logic [31:0]      perf_stall_cnt;
`endif

  int n_cmp = 0;
  int n_mis = 0;
  int grants;

  always #5 clk = ~clk;

  shared_match_pe_arbiter #(
    .NUM_REQ  (NR),
    .ADDR_W   (AW),
    .TAG_BITS (TW),
    .MLEN_W   (MW),
    .DEPTH    (DP)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .req_valid           (req_valid),
    .req_ready           (req_ready),
    .req_head_addr       (req_head_addr),
    .req_history_addr    (req_history_addr),
    .req_tag             (req_tag),
    .pe_req_valid        (pe_req_valid),
    .pe_req_ready        (pe_req_ready),
    .pe_req_head_addr    (pe_req_head_addr),
    .pe_req_history_addr (pe_req_history_addr),
    .pe_req_tag          (pe_req_tag),
    .pe_resp_valid       (pe_resp_valid),
    .pe_resp_ready       (pe_resp_ready),
    .pe_resp_tag         (pe_resp_tag),
    .pe_resp_match_len   (pe_resp_match_len),
    .resp_valid          (resp_valid),
    .resp_ready          (resp_ready),
    .resp_tag            (resp_tag),
    .resp_match_len      (resp_match_len),
    .err_orphan_resp     (err_orphan_resp)
`ifdef SHARED_ARB_PERF_CNT_EN
    ,
    .perf_grant_cnt      (perf_grant_cnt),
    .perf_stall_cnt      (perf_stall_cnt)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic fail(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_mis++;
    $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Expects the FIFO head to route to lane rv, then completes that handshake.
  task automatic pop_expect(input logic [NR-1:0] rv, input string tag);
    #1;
    n_cmp++; if (resp_valid !== rv) fail(tag, resp_valid, rv);
    n_cmp++; if (pe_resp_ready !== 1'b1) fail("pop_ready", pe_resp_ready, 1'b1);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n             = 1'b0;
    req_valid         = '0;
    pe_req_ready      = 1'b1;
    pe_resp_valid     = 1'b0;
    pe_resp_tag       = '0;
    pe_resp_match_len = '0;
    resp_ready        = 4'b1111;
    for (int i = 0; i < NR; i++) begin
      req_head_addr[i*AW +: AW]    = 16'(16'h1000 + i);
      req_history_addr[i*AW +: AW] = 16'(16'h2000 + i);
      req_tag[i*TW +: TW]          = 4'(i + 1);
    end

    #1;
    n_cmp++; if (pe_req_valid !== 1'b0) fail("rst_pe_req_valid", pe_req_valid, 1'b0);
    n_cmp++; if (req_ready !== 4'b0000) fail("rst_req_ready", req_ready, 4'b0000);
    n_cmp++; if (pe_resp_ready !== 1'b0) fail("rst_pe_resp_ready", pe_resp_ready, 1'b0);
    n_cmp++; if (err_orphan_resp !== 1'b0) fail("rst_err", err_orphan_resp, 1'b0);
    n_cmp++; if (resp_valid !== 4'b0000) fail("rst_resp_valid", resp_valid, 4'b0000);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // All requesters active: 0,1,2,3,0 with one-cycle output latency
    req_valid = 4'b1111;
    #1;
    n_cmp++; if (req_ready !== 4'b0001) fail("rr_g0_ready", req_ready, 4'b0001);
    n_cmp++; if (pe_req_valid !== 1'b0) fail("rr_pre_valid", pe_req_valid, 1'b0);
    tick();
    n_cmp++; if (pe_req_valid !== 1'b1) fail("rr_o0_valid", pe_req_valid, 1'b1);
    n_cmp++; if (pe_req_head_addr !== 16'h1000) fail("rr_o0_head", pe_req_head_addr, 16'h1000);
    n_cmp++; if (pe_req_history_addr !== 16'h2000) fail("rr_o0_hist", pe_req_history_addr, 16'h2000);
    n_cmp++; if (pe_req_tag !== 4'd1) fail("rr_o0_tag", pe_req_tag, 4'd1);
    n_cmp++; if (req_ready !== 4'b0010) fail("rr_g1_ready", req_ready, 4'b0010);
    tick();
    n_cmp++; if (pe_req_head_addr !== 16'h1001) fail("rr_o1_head", pe_req_head_addr, 16'h1001);
    n_cmp++; if (pe_req_tag !== 4'd2) fail("rr_o1_tag", pe_req_tag, 4'd2);
    n_cmp++; if (req_ready !== 4'b0100) fail("rr_g2_ready", req_ready, 4'b0100);
    tick();
    n_cmp++; if (pe_req_head_addr !== 16'h1002) fail("rr_o2_head", pe_req_head_addr, 16'h1002);
    n_cmp++; if (req_ready !== 4'b1000) fail("rr_g3_ready", req_ready, 4'b1000);
    tick();
    n_cmp++; if (pe_req_head_addr !== 16'h1003) fail("rr_o3_head", pe_req_head_addr, 16'h1003);
    n_cmp++; if (req_ready !== 4'b0001) fail("rr_g4_ready", req_ready, 4'b0001);
    tick();
    n_cmp++; if (pe_req_head_addr !== 16'h1000) fail("rr_o4_head", pe_req_head_addr, 16'h1000);
    n_cmp++; if (pe_req_valid !== 1'b1) fail("rr_o4_valid", pe_req_valid, 1'b1);
    req_valid = 4'b0000;
    tick();
    n_cmp++; if (pe_req_valid !== 1'b0) fail("rr_drained", pe_req_valid, 1'b0);

    pe_resp_valid     = 1'b1;
    pe_resp_tag       = 4'h7;
    pe_resp_match_len = 8'h33;
    #1;
    n_cmp++; if (resp_tag !== 16'h7777) fail("bcast_tag", resp_tag, 16'h7777);
    n_cmp++; if (resp_match_len !== 32'h33333333) fail("bcast_len", resp_match_len, 32'h33333333);
    pop_expect(4'b0001, "s1_pop0");
    pop_expect(4'b0010, "s1_pop1");
    pop_expect(4'b0100, "s1_pop2");
    pop_expect(4'b1000, "s1_pop3");
    pop_expect(4'b0001, "s1_pop4");
    pe_resp_valid = 1'b0;

    // Sparse requesters from rr_ptr=2: lane 3 then lane 1
    req_valid = 4'b0010;
    #1;
    n_cmp++; if (req_ready !== 4'b0010) fail("sp_setup", req_ready, 4'b0010);
    tick();
    req_valid = 4'b1010;
    #1;
    n_cmp++; if (req_ready !== 4'b1000) fail("sp_g3", req_ready, 4'b1000);
    tick();
    n_cmp++; if (pe_req_tag !== 4'd4) fail("sp_o3_tag", pe_req_tag, 4'd4);
    n_cmp++; if (req_ready !== 4'b0010) fail("sp_g1", req_ready, 4'b0010);
    tick();
    n_cmp++; if (pe_req_tag !== 4'd2) fail("sp_o1_tag", pe_req_tag, 4'd2);
    req_valid     = 4'b0000;
    pe_resp_valid = 1'b1;
    pop_expect(4'b0010, "s2_pop0");
    pop_expect(4'b1000, "s2_pop1");
    pop_expect(4'b0010, "s2_pop2");
    pe_resp_valid = 1'b0;

    // No responses: exactly DEPTH grants, then one more after a single pop
    req_valid = 4'b1111;
    grants    = 0;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (req_ready != 4'b0000) grants++;
      tick();
    end
    n_cmp++; if (grants !== 8) fail("full_grants", grants, 8);
    #1;
    n_cmp++; if (req_ready !== 4'b0000) fail("full_ready", req_ready, 4'b0000);
    pe_resp_valid = 1'b1;
    #1;
    n_cmp++; if (resp_valid !== 4'b0100) fail("full_pop_rv", resp_valid, 4'b0100);
    n_cmp++; if (pe_resp_ready !== 1'b1) fail("full_pop_ready", pe_resp_ready, 1'b1);
    n_cmp++; if (req_ready !== 4'b0000) fail("full_pop_noG", req_ready, 4'b0000);
    tick();
    pe_resp_valid = 1'b0;
    #1;
    n_cmp++; if (req_ready !== 4'b0100) fail("refill_ready", req_ready, 4'b0100);
    tick();
    n_cmp++; if (pe_req_valid !== 1'b1) fail("refill_valid", pe_req_valid, 1'b1);
    n_cmp++; if (pe_req_head_addr !== 16'h1002) fail("refill_head", pe_req_head_addr, 16'h1002);
    pe_req_ready = 1'b0;
    req_head_addr[2*AW +: AW] = 16'hBEEF;
    #1;
    n_cmp++; if (req_ready !== 4'b0000) fail("refull_ready", req_ready, 4'b0000);
    tick();
    n_cmp++; if (pe_req_valid !== 1'b1) fail("hold1_valid", pe_req_valid, 1'b1);
    n_cmp++; if (pe_req_head_addr !== 16'h1002) fail("hold1_head", pe_req_head_addr, 16'h1002);
    tick();
    n_cmp++; if (pe_req_head_addr !== 16'h1002) fail("hold2_head", pe_req_head_addr, 16'h1002);
    n_cmp++; if (pe_req_tag !== 4'd3) fail("hold2_tag", pe_req_tag, 4'd3);
    pe_req_ready = 1'b1;
    req_valid    = 4'b0000;
    tick();
    n_cmp++; if (pe_req_valid !== 1'b0) fail("hold_release", pe_req_valid, 1'b0);

    pe_resp_valid = 1'b1;
    pop_expect(4'b1000, "s3_pop0");
    pop_expect(4'b0001, "s3_pop1");
    pop_expect(4'b0010, "s3_pop2");
    pop_expect(4'b0100, "s3_pop3");
    pe_resp_valid = 1'b0;

    // Asynchronous reset with 5 IDs outstanding (one still in the output stage)
    pe_req_ready = 1'b0;
    req_valid    = 4'b0001;
    #1;
    n_cmp++; if (req_ready !== 4'b0001) fail("ar_grant", req_ready, 4'b0001);
    tick();
    req_valid = 4'b0000;
    n_cmp++; if (pe_req_valid !== 1'b1) fail("ar_stage_valid", pe_req_valid, 1'b1);
    n_cmp++; if (pe_req_head_addr !== 16'h1000) fail("ar_stage_head", pe_req_head_addr, 16'h1000);
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (pe_req_valid !== 1'b0) fail("ar_pe_req_valid", pe_req_valid, 1'b0);
    n_cmp++; if (dut.rr_ptr !== 2'd0) fail("ar_rr_ptr", dut.rr_ptr, 2'd0);
    n_cmp++; if (dut.u_fifo.cnt !== 4'd0) fail("ar_count", dut.u_fifo.cnt, 4'd0);
    tick();
    rst_n        = 1'b1;
    pe_req_ready = 1'b1;

    // Response with nothing outstanding is an orphan; flag is sticky until reset
    pe_resp_valid = 1'b1;
    #1;
    n_cmp++; if (pe_resp_ready !== 1'b0) fail("orph_ready", pe_resp_ready, 1'b0);
    n_cmp++; if (resp_valid !== 4'b0000) fail("orph_rv", resp_valid, 4'b0000);
    n_cmp++; if (err_orphan_resp !== 1'b0) fail("orph_err_pre", err_orphan_resp, 1'b0);
    tick();
    n_cmp++; if (err_orphan_resp !== 1'b1) fail("orph_err_set", err_orphan_resp, 1'b1);
    pe_resp_valid = 1'b0;
    tick();
    n_cmp++; if (err_orphan_resp !== 1'b1) fail("orph_err_hold", err_orphan_resp, 1'b1);
    rst_n = 1'b0;
    #1;
    n_cmp++; if (err_orphan_resp !== 1'b0) fail("orph_err_clr", err_orphan_resp, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();

    // Back-pressured response: lane 2 stalls, then lanes 2 and 0 in order
    req_valid = 4'b0100;
    #1;
    n_cmp++; if (req_ready !== 4'b0100) fail("bp_g2", req_ready, 4'b0100);
    tick();
    req_valid = 4'b0001;
    #1;
    n_cmp++; if (req_ready !== 4'b0001) fail("bp_g0", req_ready, 4'b0001);
    tick();
    req_valid         = 4'b0000;
    resp_ready        = 4'b1011;
    pe_resp_valid     = 1'b1;
    pe_resp_tag       = 4'h9;
    pe_resp_match_len = 8'h5A;
    #1;
    n_cmp++; if (resp_valid !== 4'b0100) fail("bp_rv", resp_valid, 4'b0100);
    n_cmp++; if (pe_resp_ready !== 1'b0) fail("bp_ready", pe_resp_ready, 1'b0);
    n_cmp++; if (resp_tag !== 16'h9999) fail("bp_tag", resp_tag, 16'h9999);
    n_cmp++; if (resp_match_len !== 32'h5A5A5A5A) fail("bp_len", resp_match_len, 32'h5A5A5A5A);
    tick();
    n_cmp++; if (resp_valid !== 4'b0100) fail("bp_rv_hold", resp_valid, 4'b0100);
    n_cmp++; if (pe_resp_ready !== 1'b0) fail("bp_ready_hold", pe_resp_ready, 1'b0);
    resp_ready = 4'b1111;
    #1;
    n_cmp++; if (pe_resp_ready !== 1'b1) fail("bp_rel_ready", pe_resp_ready, 1'b1);
    n_cmp++; if (resp_valid !== 4'b0100) fail("bp_rel_rv", resp_valid, 4'b0100);
    tick();
    n_cmp++; if (resp_valid !== 4'b0001) fail("bp_next_rv", resp_valid, 4'b0001);
    n_cmp++; if (pe_resp_ready !== 1'b1) fail("bp_next_ready", pe_resp_ready, 1'b1);
    tick();
    pe_resp_valid = 1'b0;
    #1;
    n_cmp++; if (resp_valid !== 4'b0000) fail("bp_empty_rv", resp_valid, 4'b0000);
    tick();
    n_cmp++; if (err_orphan_resp !== 1'b0) fail("bp_no_err", err_orphan_resp, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/shared_match_pe_arbiter.md
SHARED_MATCH_PE_ARBITER -- requirements
Module: shared_match_pe_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, meaning the number of job-PE requesters sharing one match PE.
REQ-002 The block SHALL have parameter ADDR_W, default `ADDR_WIDTH, meaning the width of the head and history addresses.
REQ-003 The block SHALL have parameter TAG_BITS, default `LAZY_LEN_LOG2, meaning the width of the requester-local tag.
REQ-004 The block SHALL have parameter MLEN_W, default `MATCH_LEN_WIDTH, meaning the width of the match length.
REQ-005 The block SHALL have parameter DEPTH, default 8 (a power of 2), meaning the maximum number of outstanding requests at the match PE.
REQ-006 The block SHALL have these clock and reset ports:
- clk  in  1  the single clock.
- rst_n  in  1  asynchronous active-low reset.
REQ-007 The block SHALL have these requester request ports:
- req_valid  in  NUM_REQ
- req_ready  out  NUM_REQ
- req_head_addr  in  NUM_REQ*ADDR_W
- req_history_addr  in  NUM_REQ*ADDR_W
- req_tag  in  NUM_REQ*TAG_BITS
REQ-008 The block SHALL have these match-PE request ports:
- pe_req_valid  out  1
- pe_req_ready  in  1
- pe_req_head_addr  out  ADDR_W
- pe_req_history_addr  out  ADDR_W
- pe_req_tag  out  TAG_BITS
REQ-009 The block SHALL have these match-PE response ports:
- pe_resp_valid  in  1
- pe_resp_ready  out  1
- pe_resp_tag  in  TAG_BITS
- pe_resp_match_len  in  MLEN_W
REQ-010 The block SHALL have these requester response ports:
- resp_valid  out  NUM_REQ
- resp_ready  in  NUM_REQ
- resp_tag  out  NUM_REQ*TAG_BITS
- resp_match_len  out  NUM_REQ*MLEN_W
REQ-011 The block SHALL have err_orphan_resp  out  1, a sticky flag for a response arriving with no request outstanding.

Function
REQ-012 Lane i of every packed bus SHALL occupy bits [i*W +: W].
REQ-013 The block SHALL grant at most one requester per cycle, and only when the output stage is free (!pe_req_valid || pe_req_ready) and outstanding < DEPTH.
REQ-014 Outstanding SHALL count the IDs held in the ID FIFO, including the request held in the output stage.
REQ-015 Arbitration SHALL be round-robin:
- search starts at rr_ptr;
- after a grant to requester w, rr_ptr SHALL become (w+1) mod NUM_REQ;
- rr_ptr SHALL be unchanged on cycles without a grant.
REQ-016 req_ready SHALL be combinational and one-hot (or zero); req_ready[i] SHALL be high only for the granted i, and a transfer occurs when req_valid[i] && req_ready[i].
REQ-017 A granted request SHALL be registered into the output stage, so latency is 1 cycle from acceptance to pe_req_valid.
REQ-018 While pe_req_valid && !pe_req_ready, the output-stage contents SHALL hold stable.
REQ-019 On grant, the winner index SHALL be pushed into an in-order ID FIFO of DEPTH entries; the match PE responds in request order.
REQ-020 For each requester i, resp_valid[i] SHALL equal pe_resp_valid && fifo_nonempty && (fifo_head == i).
REQ-021 resp_tag and resp_match_len SHALL carry pe_resp_tag and pe_resp_match_len broadcast to all lanes.
REQ-022 pe_resp_ready SHALL equal fifo_nonempty && resp_ready[fifo_head].
REQ-023 On a pe_resp handshake, the FIFO SHALL pop.
REQ-024 A simultaneous push and pop SHALL leave outstanding unchanged; a push at outstanding==DEPTH is impossible by REQ-013.
REQ-025 When pe_resp_valid is high and the FIFO is empty, pe_resp_ready SHALL be 0 and err_orphan_resp SHALL set, holding until reset.
REQ-026 FIFO pointers SHALL wrap modulo DEPTH.

Reset
REQ-027 When rst_n is low, the following SHALL be cleared: pe_req_valid=0, rr_ptr=0, FIFO read/write pointers and count=0, err_orphan_resp=0, and perf counters=0.
REQ-028 Output-stage data registers SHALL NOT be reset.
REQ-029 Reset asserted mid-operation SHALL discard all in-flight IDs; responses arriving after reset SHALL be treated as orphans.

Configuration
REQ-030 The macro SHARED_ARB_PERF_CNT_EN SHALL control performance counters:
- when defined, the block SHALL add outputs perf_grant_cnt (out NUM_REQ*32, per-requester grant count) and perf_stall_cnt (out 32, cycles with any req_valid but no grant), both wrapping at 2^32;
- when undefined, these ports and counters SHALL be absent.

Structure
REQ-031 NUM_REQ/DEPTH defaults and the requester-ID width ($clog2(NUM_REQ)) SHALL live in the shared parameters header.
REQ-032 The ID FIFO SHALL be one sub-module, arb_id_fifo.

Verification
REQ-033 The bench SHALL cover the following directed scenarios:
- All 4 req_valid held high, pe_req_ready=1 -> grants in order 0,1,2,3,0; each pe_req appears 1 cycle after its accept.
- req_valid=4'b1010 with rr_ptr=2 -> grant 3, then 1.
- pe_resp_ready held 0, DEPTH=8 -> exactly 8 grants, then req_ready=0 until the first pe_resp handshake, after which 1 more grant is allowed.
- Responses for IDs 2,0 with resp_ready[2]=0 -> pe_resp_ready=0 and resp_valid[2]=1 holds; releasing resp_ready delivers to lane 2 then lane 0.
- pe_resp_valid=1 with empty FIFO -> pe_resp_ready=0 and err_orphan_resp=1 the next cycle, holding until rst_n low.
- rst_n pulsed low with 5 outstanding -> pe_req_valid=0, count=0, rr_ptr=0 immediately (asynchronous).
